stage_decode_sb: RTL and testbench

//  Parametrised decode/register-read stage with scoreboard hazard detection and write-back bypass.

---
 rtl/tinycpu_pipe_pkg.sv | 25 ++
 rtl/decode_scoreboard.sv | 69 ++++++
 rtl/stage_decode_sb.sv | 165 ++++++++++++++++
 tb/tb_stage_decode_sb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tinycpu_pipe_pkg
// Purpose  : Shared pipeline constants and helpers for the tinycpu decode stage.
//            Default datapath widths, the NOP encoding injected into bubbles,
//            and the register-address width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tinycpu_pipe_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    // Encoding placed in the EX register whenever it carries no instruction.
    localparam int INSTR_NOP = 'h0;

    // Register-address width; a single-register file still needs one bit.
    function automatic int reg_addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage : tinycpu_pipe_pkg

`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : decode_scoreboard
// Purpose  : One pending bit per architectural register, marking destinations
//            that have been issued but not yet written back.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            set_en_i/addr_i   - mark a register pending (issue with rd)
//            clr_wb_*_i        - write-back clear
//            clr_sq_*_i        - clear for a squashed, never-retiring instr
//            qry_addr_i[3]     - rs0, rs1, rd query addresses
//            pend_o[3]         - pending and not being written back this cycle
// Revision : 1.0 - initial release
// ============================================================================
module decode_scoreboard
    import tinycpu_pipe_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = reg_addr_w(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en_i,
    input  logic [AW-1:0]      set_addr_i,
    input  logic               clr_wb_en_i,
    input  logic [AW-1:0]      clr_wb_addr_i,
    input  logic               clr_sq_en_i,
    input  logic [AW-1:0]      clr_sq_addr_i,
    input  logic [2:0][AW-1:0] qry_addr_i,
    output logic [2:0]         pend_o
);

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_bits
        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            // Register 0 is hard-wired: never pending.
            assign sb_d[r] = 1'b0;
        end else begin : g_live
            logic w_set_hit;
            logic w_clr_hit;
            assign w_set_hit = set_en_i    && (set_addr_i    == AW'(r));
            assign w_clr_hit = (clr_wb_en_i && (clr_wb_addr_i == AW'(r))) ||
                               (clr_sq_en_i && (clr_sq_addr_i == AW'(r)));
            // A new issue wins over a retiring write to the same register:
            // the newer producer is still outstanding.
            assign sb_d[r] = w_set_hit ? 1'b1 : (w_clr_hit ? 1'b0 : sb_q[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // A register being written back this cycle is no longer a hazard: the
    // bypass path supplies its value.
    for (genvar q = 0; q < 3; q++) begin : g_query
        assign pend_o[q] = sb_q[qry_addr_i[q]] &&
                           !(clr_wb_en_i && (clr_wb_addr_i == qry_addr_i[q]));
    end

endmodule : decode_scoreboard

`default_nettype wire

// File: rtl/stage_decode_sb.sv
`default_nettype none
// ============================================================================
// Module   : stage_decode_sb
// Purpose  : Decode/register-read stage. Reads two operands with write-back
//            bypass, stalls on RAW/WAW hazards via a scoreboard, and holds a
//            valid/ready register into EX. Squash kills the decode-side and
//            output-register instructions.
// Ports    : clk, rst                      - clock, sync active-high reset
//            in_valid/in_instr/in_ready    - fetch handshake
//            rs0_*/rs1_*/rd_*              - operand / destination fields
//            squash                        - kill in-flight instruction
//            ex_ready                      - EX consumes out_*
//            wb_en/wb_addr/wb_data         - write-back port
//            fwd_data0/1, hazard           - combinational early outputs
//            out_*                         - registered EX payload
// Revision : 1.0 - initial release
// ============================================================================
module stage_decode_sb
    import tinycpu_pipe_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int INSTR_W  = INSTR_W_DEF,
    parameter  int NUM_REGS = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = reg_addr_w(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               rs0_en,
    input  logic [AW-1:0]      rs0_addr,
    input  logic               rs1_en,
    input  logic [AW-1:0]      rs1_addr,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic               in_ready,
    input  logic               squash,
    input  logic               ex_ready,
    input  logic               wb_en,
    input  logic [AW-1:0]      wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  fwd_data0,
    output logic [DATA_W-1:0]  fwd_data1,
    output logic               hazard,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_data0,
    output logic [DATA_W-1:0]  out_data1,
    output logic               out_rd_en,
    output logic [AW-1:0]      out_rd_addr
);

    logic [DATA_W-1:0]  rf_q [NUM_REGS];
    logic               wb_write;
    logic               accept;
    logic               out_load;
    logic [2:0]         pend;

    logic               out_valid_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic [DATA_W-1:0]  out_data0_q;
    logic [DATA_W-1:0]  out_data1_q;
    logic               out_rd_en_q;
    logic [AW-1:0]      out_rd_addr_q;

    // ------------------------------------------------------------------
    // Register file and bypass
    // ------------------------------------------------------------------
    assign wb_write = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_write) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Zero-register check comes first so a write-back to r0 is never bypassed.
    always_comb begin
        fwd_data0 = rf_q[rs0_addr];
        if ((ZERO_REG != 0) && (rs0_addr == '0)) begin
            fwd_data0 = '0;
        end else if (wb_en && (wb_addr == rs0_addr)) begin
            fwd_data0 = wb_data;
        end

        fwd_data1 = rf_q[rs1_addr];
        if ((ZERO_REG != 0) && (rs1_addr == '0)) begin
            fwd_data1 = '0;
        end else if (wb_en && (wb_addr == rs1_addr)) begin
            fwd_data1 = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and handshake
    // ------------------------------------------------------------------
    decode_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .set_en_i      (accept && rd_en),
        .set_addr_i    (rd_addr),
        .clr_wb_en_i   (wb_en),
        .clr_wb_addr_i (wb_addr),
        // The squashed instruction in the EX register never writes back,
        // so its destination must be released here.
        .clr_sq_en_i   (squash && out_valid_q && out_rd_en_q),
        .clr_sq_addr_i (out_rd_addr_q),
        .qry_addr_i    ({rd_addr, rs1_addr, rs0_addr}),
        .pend_o        (pend)
    );

    assign hazard   = in_valid && ((rs0_en && pend[0]) ||
                                   (rs1_en && pend[1]) ||
                                   (rd_en  && pend[2]));
    assign out_load = !out_valid_q || ex_ready;
    assign in_ready = !hazard && !squash && out_load;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // EX output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_data0_q   <= '0;
            out_data1_q   <= '0;
            out_rd_en_q   <= 1'b0;
            out_rd_addr_q <= '0;
        end else if (squash) begin
            // accept is already blocked by squash, so only the bubble remains.
            out_valid_q <= 1'b0;
            out_instr_q <= INSTR_W'(INSTR_NOP);
        end else if (out_load) begin
            out_valid_q <= accept;
            if (accept) begin
                out_instr_q   <= in_instr;
                out_data0_q   <= fwd_data0;
                out_data1_q   <= fwd_data1;
                out_rd_en_q   <= rd_en;
                out_rd_addr_q <= rd_addr;
            end else begin
                out_instr_q   <= INSTR_W'(INSTR_NOP);
            end
        end
    end

    assign out_valid   = out_valid_q && !squash;
    assign out_instr   = out_instr_q;
    assign out_data0   = out_data0_q;
    assign out_data1   = out_data1_q;
    assign out_rd_en   = out_rd_en_q;
    assign out_rd_addr = out_rd_addr_q;

endmodule : stage_decode_sb

`default_nettype wire

// File: tb/tb_stage_decode_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_decode_sb
// Purpose  : Self-checking bench for stage_decode_sb. The driver pushes the
//            expected EX payload of every instruction it expects to be
//            accepted; a monitor pops and compares on each EX transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_decode_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        rs0_en, rs1_en, rd_en;
    logic [4:0]  rs0_addr, rs1_addr, rd_addr;
    logic        in_ready;
    logic        squash;
    logic        ex_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] fwd_data0, fwd_data1;
    logic        hazard;
    logic        out_valid;
    logic [31:0] out_instr, out_data0, out_data1;
    logic        out_rd_en;
    logic [4:0]  out_rd_addr;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rd_en;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    stage_decode_sb #(
        .DATA_W   (32),
        .INSTR_W  (32),
        .NUM_REGS (32),
        .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .rs0_en      (rs0_en),
        .rs0_addr    (rs0_addr),
        .rs1_en      (rs1_en),
        .rs1_addr    (rs1_addr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .in_ready    (in_ready),
        .squash      (squash),
        .ex_ready    (ex_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .fwd_data0   (fwd_data0),
        .fwd_data1   (fwd_data1),
        .hazard      (hazard),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_data0   (out_data0),
        .out_data1   (out_data1),
        .out_rd_en   (out_rd_en),
        .out_rd_addr (out_rd_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply one cycle's inputs just after the edge, then let them settle.
    task automatic drv(input logic v, input logic [31:0] ins,
                       input logic e0, input logic [4:0] a0,
                       input logic e1, input logic [4:0] a1,
                       input logic ed, input logic [4:0] ad,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic er, input logic sq);
        in_valid = v;   in_instr = ins;
        rs0_en   = e0;  rs0_addr = a0;
        rs1_en   = e1;  rs1_addr = a1;
        rd_en    = ed;  rd_addr  = ad;
        wb_en    = we;  wb_addr  = wa;  wb_data = wd;
        ex_ready = er;  squash   = sq;
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] d0,
                        input logic [31:0] d1, input logic ed, input logic [4:0] ad);
        exp_t e;
        e.instr = ins; e.d0 = d0; e.d1 = d1; e.rd_en = ed; e.rd = ad;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        drv(0, 0, 0, 0, 0, 0, 0, 0, we, wa, wd, 1, 0);
        nxt();
    endtask

    // Monitor: every EX transfer must match the oldest expected payload.
    always @(negedge clk) begin
        if (!rst && out_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_instr", out_instr, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_instr",   out_instr,          e.instr);
                chk("out_data0",   out_data0,          e.d0);
                chk("out_data1",   out_data1,          e.d1);
                chk("out_rd_en",   {31'd0, out_rd_en}, {31'd0, e.rd_en});
                chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, e.rd});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drv(0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_fwd_data0", fwd_data0, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_hazard",    {31'd0, hazard}, 0);
        chk("rst_out_instr", out_instr, 0);
        rst = 1'b0;
        nxt();

        // Write-back bypass into operand 0
        drv(1, 32'h1001, 1, 3, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 1, 0);
        chk("byp_fwd_data0", fwd_data0, 32'hDEADBEEF);
        chk("byp_in_ready",  {31'd0, in_ready}, 1);
        push(32'h1001, 32'hDEADBEEF, 0, 0, 0);
        nxt();

        // RAW on rd=7
        drv(1, 32'h2002, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0);
        chk("raw_issue_ready", {31'd0, in_ready}, 1);
        push(32'h2002, 0, 0, 1, 7);
        nxt();
        drv(1, 32'h3003, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0);
        chk("raw_hazard",   {31'd0, hazard}, 1);
        chk("raw_in_ready", {31'd0, in_ready}, 0);
        nxt();
        drv(1, 32'h3003, 0, 0, 1, 7, 0, 0, 1, 7, 32'h42, 1, 0);
        chk("raw_wb_hazard",   {31'd0, hazard}, 0);
        chk("raw_wb_in_ready", {31'd0, in_ready}, 1);
        chk("raw_wb_fwd1",     fwd_data1, 32'h42);
        push(32'h3003, 0, 32'h42, 0, 0);
        nxt();
        idle(0, 0, 0);

        // Backpressure
        drv(1, 32'h4004, 1, 3, 0, 0, 1, 10, 0, 0, 0, 1, 0);
        push(32'h4004, 32'hDEADBEEF, 0, 1, 10);
        nxt();
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h5005, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("bp_in_ready",  {31'd0, in_ready}, 0);
            chk("bp_out_valid", {31'd0, out_valid}, 1);
            chk("bp_out_instr", out_instr, 32'h4004);
            chk("bp_out_data0", out_data0, 32'hDEADBEEF);
            nxt();
        end
        drv(1, 32'h5005, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("bp_release_ready", {31'd0, in_ready}, 1);
        push(32'h5005, 32'h42, 0, 0, 0);
        nxt();
        idle(1, 10, 32'h77);

        // Squash of an instruction holding rd=9
        drv(1, 32'h6006, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 0);
        chk("sq_issue_ready", {31'd0, in_ready}, 1);
        nxt();
        drv(1, 32'h7007, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("sq_out_valid", {31'd0, out_valid}, 0);
        chk("sq_hazard",    {31'd0, hazard}, 1);
        chk("sq_in_ready",  {31'd0, in_ready}, 0);
        nxt();
        drv(1, 32'h7007, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("sq_next_out_instr", out_instr, 0);
        chk("sq_next_out_valid", {31'd0, out_valid}, 0);
        chk("sq_next_hazard",    {31'd0, hazard}, 0);
        chk("sq_next_in_ready",  {31'd0, in_ready}, 1);
        push(32'h7007, 0, 0, 0, 0);
        nxt();

        // Same-cycle set and write-back of r12: the set must win
        drv(1, 32'hA00A, 0, 0, 0, 0, 1, 12, 1, 12, 32'h11, 1, 0);
        chk("setwin_issue_ready", {31'd0, in_ready}, 1);
        push(32'hA00A, 0, 0, 1, 12);
        nxt();
        drv(1, 32'hB00B, 1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("setwin_hazard", {31'd0, hazard}, 1);
        nxt();
        drv(1, 32'hC00C, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1, 0);
        chk("waw_hazard", {31'd0, hazard}, 1);
        nxt();
        drv(1, 32'hB00B, 1, 12, 0, 0, 0, 0, 1, 12, 32'h55, 1, 0);
        chk("setwin_wb_ready", {31'd0, in_ready}, 1);
        push(32'hB00B, 32'h55, 0, 0, 0);
        nxt();

        // Zero register
        drv(1, 32'h8008, 1, 0, 0, 0, 1, 0, 1, 0, 32'h1234, 1, 0);
        chk("zr_fwd_data0", fwd_data0, 0);
        chk("zr_in_ready",  {31'd0, in_ready}, 1);
        push(32'h8008, 0, 0, 1, 0);
        nxt();
        drv(1, 32'h9009, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("zr_read_hazard", {31'd0, hazard}, 0);
        chk("zr_read_fwd0",   fwd_data0, 0);
        chk("zr_read_ready",  {31'd0, in_ready}, 1);
        push(32'h9009, 0, 0, 0, 0);
        nxt();

        // Drain, bounded
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            idle(0, 0, 0);
        end
        idle(0, 0, 0);
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stage_decode_sb

`default_nettype wire
